barrett_mul_sched_2ch: RTL and testbench

- Two-requester scheduler that shares one 64-bit Barrett modular multiplier (fixed pipeline latency, global enable/clear) between two independent operand streams.
- Sequences operand issue with a round-robin arbiter and tracks in-flight operations with a tag shift register.
- Returns each result, with its requester ID, through a credit-protected result FIFO so the free-running pipeline never overflows.
- Also owns the multiplier's modulus/K/U configuration; configuration changes are allowed only while quiescent.

---
 rtl/barrett_sched_pkg.sv | 22 ++
 rtl/sync_fifo_fwft.sv | 66 ++++++
 rtl/barrett_mul_sched_2ch.sv | 230 +++++++++++++++++++++++
 tb/tb_barrett_mul_sched_2ch.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_sched_pkg.sv
// Shared types and constants for the two-channel Barrett multiplier scheduler.
package barrett_sched_pkg;

   localparam int DW             = 64;
   localparam int LATENCY_DEF    = 19;
   localparam int FIFO_DEPTH_DEF = 32;
   localparam int KW             = 7;

   typedef logic ch_id_t;

   typedef struct packed {
      logic   valid;
      ch_id_t id;
   } tag_t;

   // The result FIFO must absorb every in-flight result plus one, and its
   // pointers wrap naturally only when the depth is a power of two.
   function automatic bit depth_ok(input int depth, input int lat);
      return (depth >= lat + 1) && (depth > 1) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
module sync_fifo_fwft #(
   parameter int W     = 65,
   parameter int DEPTH = 32
) (
   input  logic                     iClk,
   input  logic                     iRstN,
   input  logic                     iClr,
   input  logic                     iPush,
   input  logic [W-1:0]             iData,
   input  logic                     iPop,
   output logic                     oValid,
   output logic [W-1:0]             oData,
   output logic [$clog2(DEPTH):0]   oCount
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   // Next pointer/count state; a push into a full FIFO is only taken alongside a pop.
   always_comb begin
      do_pop   = iPop & (count_q != '0);
      do_push  = iPush & ((count_q != FULL) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      count_d = count_q + 1'b1;
      else if (~do_push & do_pop) count_d = count_q - 1'b1;
      if (iClr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless until the count says otherwise.
   always_ff @(posedge iClk) begin
      if (do_push) mem_q[wr_ptr_q] <= iData;
   end

   assign oValid = (count_q != '0);
   assign oData  = mem_q[rd_ptr_q];
   assign oCount = count_q;

endmodule

// File: rtl/barrett_mul_sched_2ch.sv
// Two-channel round-robin scheduler in front of a shared, free-running
// Barrett modular multiplier. Results return in issue order through a
// credit-protected FWFT FIFO.
// Optional build macro: BARRETT_SCHED_PERF_EN enables the performance counters.
module barrett_mul_sched_2ch
   import barrett_sched_pkg::*;
#(
   parameter int LATENCY    = LATENCY_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iClr,
   input  logic              iReqValid0,
   output logic              oReqReady0,
   input  logic [DW-1:0]     iReqA0,
   input  logic [DW-1:0]     iReqB0,
   input  logic              iReqValid1,
   output logic              oReqReady1,
   input  logic [DW-1:0]     iReqA1,
   input  logic [DW-1:0]     iReqB1,
   output logic              oRspValid,
   input  logic              iRspReady,
   output logic              oRspId,
   output logic [DW-1:0]     oRspData,
   input  logic              iCfgValid,
   output logic              oCfgReady,
   input  logic [DW-1:0]     iCfgMod,
   input  logic [KW-1:0]     iCfgK,
   input  logic [2*DW-1:0]   iCfgU,
   output logic              oMulEn,
   output logic              oMulClr,
   output logic [DW-1:0]     oMulData0,
   output logic [DW-1:0]     oMulData1,
   output logic [DW-1:0]     oMulMod,
   output logic [KW-1:0]     oMulK,
   output logic [2*DW-1:0]   oMulU,
   input  logic [DW-1:0]     iMulData,
   output logic [31:0]       oPerfOps0,
   output logic [31:0]       oPerfOps1,
   output logic [31:0]       oPerfStall
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = $clog2(LATENCY + 1);
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] CREDITS = OW'(FIFO_DEPTH);

   if (!depth_ok(FIFO_DEPTH, LATENCY)) begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of two and at least LATENCY+1");
   end

   tag_t            tag_q [LATENCY];
   tag_t            tag_d [LATENCY];
   logic [IW-1:0]   inflight_q, inflight_d;
   ch_id_t          last_q, last_d;
   logic            cfg_loaded_q, cfg_loaded_d;
   logic [DW-1:0]   mod_q, mod_d;
   logic [KW-1:0]   k_q, k_d;
   logic [2*DW-1:0] u_q, u_d;
   logic [DW-1:0]   mul_a_q, mul_a_d;
   logic [DW-1:0]   mul_b_q, mul_b_d;
   logic            en_q;

   logic [CW-1:0]   fifo_count;
   logic [OW-1:0]   outstanding;
   logic            fifo_vld;
   logic [DW:0]     fifo_data;
   logic            cfg_ready, cfg_accept, issue_allowed;
   logic            grant0, grant1, issue, exit_vld;
   ch_id_t          win_id;

   // Credit check, round-robin arbitration and configuration handshake.
   always_comb begin
      outstanding   = OW'(inflight_q) + OW'(fifo_count);
      cfg_ready     = (inflight_q == '0) & (fifo_count == '0) & ~iClr;
      cfg_accept    = iCfgValid & cfg_ready;
      issue_allowed = cfg_loaded_q & (outstanding < CREDITS) & ~cfg_accept & ~iClr;
      // last_q == 1 means channel 1 won last, so channel 0 is favoured.
      grant0        = iReqValid0 & (~iReqValid1 | last_q);
      grant1        = iReqValid1 & (~iReqValid0 | ~last_q);
      issue         = issue_allowed & (grant0 | grant1);
      win_id        = issue_allowed & grant1;
      exit_vld      = tag_q[LATENCY-1].valid & ~iClr;
   end

   // Next state for operands, arbiter pointer, in-flight count and configuration.
   always_comb begin
      mul_a_d      = '0;
      mul_b_d      = '0;
      last_d       = last_q;
      inflight_d   = inflight_q;
      cfg_loaded_d = cfg_loaded_q | cfg_accept;
      mod_d        = mod_q;
      k_d          = k_q;
      u_d          = u_q;
      if (issue) begin
         mul_a_d = win_id ? iReqA1 : iReqA0;
         mul_b_d = win_id ? iReqB1 : iReqB0;
         last_d  = win_id;
      end
      if (issue & ~exit_vld)      inflight_d = inflight_q + IW'(1);
      else if (~issue & exit_vld) inflight_d = inflight_q - IW'(1);
      if (cfg_accept) begin
         mod_d = iCfgMod;
         k_d   = iCfgK;
         u_d   = iCfgU;
      end
      if (iClr) begin
         last_d     = 1'b1;
         inflight_d = '0;
      end
   end

   // Tag pipe shadows the multiplier: a bubble is pushed on every idle cycle.
   always_comb begin
      tag_d[0].valid = issue;
      tag_d[0].id    = win_id;
      for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
      if (iClr) begin
         for (int i = 0; i < LATENCY; i++) tag_d[i] = '0;
      end
   end

   // Control, configuration and operand registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         en_q         <= 1'b0;
         last_q       <= 1'b1;
         inflight_q   <= '0;
         cfg_loaded_q <= 1'b0;
         mod_q        <= '0;
         k_q          <= '0;
         u_q          <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
      end else begin
         en_q         <= 1'b1;
         last_q       <= last_d;
         inflight_q   <= inflight_d;
         cfg_loaded_q <= cfg_loaded_d;
         mod_q        <= mod_d;
         k_q          <= k_d;
         u_q          <= u_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
      end
   end

   // Tag pipe registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
      end
   end

   sync_fifo_fwft #(
      .W     (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iClr   (iClr),
      .iPush  (exit_vld),
      .iData  ({tag_q[LATENCY-1].id, iMulData}),
      .iPop   (iRspReady),
      .oValid (fifo_vld),
      .oData  (fifo_data),
      .oCount (fifo_count)
   );

`ifdef BARRETT_SCHED_PERF_EN
   logic [31:0] ops0_q, ops0_d;
   logic [31:0] ops1_q, ops1_d;
   logic [31:0] stall_q, stall_d;

   // Accepted-request and stalled-cycle counters, wrapping, flushed by iClr.
   always_comb begin
      ops0_d  = ops0_q;
      ops1_d  = ops1_q;
      stall_d = stall_q;
      if (issue & ~win_id) ops0_d = ops0_q + 32'd1;
      if (issue & win_id)  ops1_d = ops1_q + 32'd1;
      if ((iReqValid0 | iReqValid1) & ~issue) stall_d = stall_q + 32'd1;
      if (iClr) begin
         ops0_d  = '0;
         ops1_d  = '0;
         stall_d = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         ops0_q  <= '0;
         ops1_q  <= '0;
         stall_q <= '0;
      end else begin
         ops0_q  <= ops0_d;
         ops1_q  <= ops1_d;
         stall_q <= stall_d;
      end
   end

   assign oPerfOps0  = ops0_q;
   assign oPerfOps1  = ops1_q;
   assign oPerfStall = stall_q;
`else
   assign oPerfOps0  = '0;
   assign oPerfOps1  = '0;
   assign oPerfStall = '0;
`endif

   assign oReqReady0 = issue_allowed & grant0;
   assign oReqReady1 = issue_allowed & grant1;
   assign oCfgReady  = cfg_ready;
   assign oRspValid  = fifo_vld;
   assign oRspId     = fifo_vld & fifo_data[DW];
   assign oRspData   = fifo_vld ? fifo_data[DW-1:0] : '0;
   assign oMulEn     = en_q;
   assign oMulClr    = iClr;
   assign oMulData0  = mul_a_q;
   assign oMulData1  = mul_b_q;
   assign oMulMod    = mod_q;
   assign oMulK      = k_q;
   assign oMulU      = u_q;

endmodule

// File: tb/tb_barrett_mul_sched_2ch.sv
// Directed bench for barrett_mul_sched_2ch with a behavioural multiplier model.
module tb_barrett_mul_sched_2ch;
   import barrett_sched_pkg::*;

   localparam int LAT   = 19;
   localparam int DEPTH = 32;

   logic            iClk = 1'b0;
   logic            iRstN = 1'b0;
   logic            iClr = 1'b0;
   logic            iReqValid0 = 1'b0, iReqValid1 = 1'b0;
   logic            oReqReady0, oReqReady1;
   logic [DW-1:0]   iReqA0 = '0, iReqB0 = '0, iReqA1 = '0, iReqB1 = '0;
   logic            oRspValid, oRspId;
   logic            iRspReady = 1'b0;
   logic [DW-1:0]   oRspData;
   logic            iCfgValid = 1'b0;
   logic            oCfgReady;
   logic [DW-1:0]   iCfgMod = '0;
   logic [KW-1:0]   iCfgK = '0;
   logic [2*DW-1:0] iCfgU = '0;
   logic            oMulEn, oMulClr;
   logic [DW-1:0]   oMulData0, oMulData1, oMulMod;
   logic [KW-1:0]   oMulK;
   logic [2*DW-1:0] oMulU;
   logic [DW-1:0]   iMulData;
   logic [31:0]     oPerfOps0, oPerfOps1, oPerfStall;

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   barrett_mul_sched_2ch #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .iClk(iClk), .iRstN(iRstN), .iClr(iClr),
      .iReqValid0(iReqValid0), .oReqReady0(oReqReady0), .iReqA0(iReqA0), .iReqB0(iReqB0),
      .iReqValid1(iReqValid1), .oReqReady1(oReqReady1), .iReqA1(iReqA1), .iReqB1(iReqB1),
      .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspId(oRspId), .oRspData(oRspData),
      .iCfgValid(iCfgValid), .oCfgReady(oCfgReady),
      .iCfgMod(iCfgMod), .iCfgK(iCfgK), .iCfgU(iCfgU),
      .oMulEn(oMulEn), .oMulClr(oMulClr), .oMulData0(oMulData0), .oMulData1(oMulData1),
      .oMulMod(oMulMod), .oMulK(oMulK), .oMulU(oMulU), .iMulData(iMulData),
      .oPerfOps0(oPerfOps0), .oPerfOps1(oPerfOps1), .oPerfStall(oPerfStall)
   );

   // Multiplier model: operands registered at edge N yield a result that the
   // scheduler samples at edge N+LAT.
   function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, b, m);
      logic [2*DW-1:0] p;
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      if (m == '0) return '0;
      return DW'(p % {{DW{1'b0}}, m});
   endfunction

   logic [DW-1:0] mpipe [LAT-1];
   always @(posedge iClk) begin
      mpipe[0] <= mulmod(oMulData0, oMulData1, oMulMod);
      for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
   end
   assign iMulData = mpipe[LAT-2];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic do_cfg(input string tag);
      iCfgValid = 1'b1;
      iCfgMod   = 64'd97;
      iCfgK     = 7'd7;
      iCfgU     = 128'd168;
      #1;
      chk({tag, "_cfg_ready"}, oCfgReady, 1);
      tick();
      iCfgValid = 1'b0;
   endtask

   // One request on channel ch; response expected in cycle LAT+1 counting the handshake cycle as 1.
   task automatic single(input logic ch, input logic [DW-1:0] a, b, exp, input string tag);
      int n;
      if (ch) begin iReqValid1 = 1'b1; iReqA1 = a; iReqB1 = b; end
      else    begin iReqValid0 = 1'b1; iReqA0 = a; iReqB0 = b; end
      #1;
      chk({tag, "_ready"}, ch ? oReqReady1 : oReqReady0, 1);
      tick();
      iReqValid0 = 1'b0;
      iReqValid1 = 1'b0;
      n = 1;
      while (!oRspValid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, LAT + 1);
      chk({tag, "_id"}, oRspId, ch);
      chk({tag, "_data"}, oRspData, exp);
      iRspReady = 1'b1;
      tick();
      iRspReady = 1'b0;
      chk({tag, "_popped"}, oRspValid, 0);
   endtask

   initial begin
      int n, acc, acc1, bad, cyc;

      // Reset state
      repeat (3) tick();
      chk("rst_rsp_valid", oRspValid, 0);
      chk("rst_mul_en", oMulEn, 0);
      chk("rst_mul_a", oMulData0, 0);
      chk("rst_mul_mod", oMulMod, 0);
      chk("rst_rsp_data", oRspData, 0);
      chk("rst_perf_ops0", oPerfOps0, 0);
      iRstN = 1'b1;

      // Requests are never accepted before configuration
      iReqValid0 = 1'b1; iReqA0 = 64'd12; iReqB0 = 64'd13;
      acc = 0; bad = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (oReqReady0) acc++;
         if (oRspValid) bad++;
         tick();
      end
      iReqValid0 = 1'b0;
      chk("nocfg_accepts", acc, 0);
      chk("nocfg_rsp", bad, 0);
      chk("mul_en", oMulEn, 1);

      do_cfg("init");
      chk("cfg_mod", oMulMod, 97);
      chk("cfg_k", oMulK, 7);
      chk("cfg_u", oMulU, 168);

      // Basic latency and result: 12*13 mod 97 = 59
      single(1'b0, 64'd12, 64'd13, 64'd59, "basic");

      // Round robin with both channels always valid
      iClr = 1'b1; tick(); iClr = 1'b0;
      iRspReady = 1'b1;
      iReqValid0 = 1'b1; iReqA0 = 64'd96; iReqB0 = 64'd96;
      iReqValid1 = 1'b1; iReqA1 = 64'd2;  iReqB1 = 64'd50;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rr_grant%0d", i), {oReqReady1, oReqReady0}, (i % 2) ? 2'b10 : 2'b01);
         tick();
      end
      iReqValid0 = 1'b0; iReqValid1 = 1'b0;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         if (oRspValid) begin
            chk($sformatf("rr_id%0d", n), oRspId, n % 2);
            chk($sformatf("rr_data%0d", n), oRspData, (n % 2) ? 3 : 1);
            n++;
         end
         tick();
         cyc++;
      end
      chk("rr_rsp_count", n, 4);
      iRspReady = 1'b0;

      // Credit limit with the consumer stalled
      iReqValid0 = 1'b1; iReqA0 = 64'd12; iReqB0 = 64'd13;
      acc = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (oReqReady0) acc++;
         tick();
      end
      chk("bp_accepts", acc, DEPTH);
      chk("bp_ready_low", oReqReady0, 0);
      chk("bp_rsp_valid", oRspValid, 1);
      iRspReady = 1'b1; tick(); iRspReady = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (oReqReady0) acc++;
         tick();
      end
      chk("bp_after_pop", acc, 1);
      iReqValid0 = 1'b0;
      iRspReady = 1'b1;
      n = 0; bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (oRspValid) begin
            n++;
            if (oRspData != 64'd59 || oRspId != 1'b0) bad++;
         end
         tick();
      end
      iRspReady = 1'b0;
      chk("bp_drain_count", n, DEPTH);
      chk("bp_drain_data", bad, 0);

      // Configuration is held off until everything has drained and been popped
      iReqValid0 = 1'b1;
      acc = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (oReqReady0) acc++;
         tick();
      end
      iReqValid0 = 1'b0;
      chk("cfgbusy_accepts", acc, 3);
      iCfgValid = 1'b1; iCfgMod = 64'd97; iCfgK = 7'd7; iCfgU = 128'd168;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (oCfgReady) bad++;
         tick();
      end
      chk("cfgbusy_rsp", oRspValid, 1);
      iRspReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (oCfgReady) bad++;
         tick();
      end
      iRspReady = 1'b0;
      chk("cfgbusy_ready", bad, 0);
      iReqValid0 = 1'b1;
      #1;
      chk("cfg_ready_drained", oCfgReady, 1);
      chk("cfg_issue_suppressed", oReqReady0, 0);
      tick();
      iCfgValid = 1'b0;
      #1;
      chk("cfg_issue_after", oReqReady0, 1);
      iReqValid0 = 1'b0;
      tick();

      // Flush with operations in flight and in the FIFO
      iReqValid1 = 1'b1; iReqA1 = 64'd2; iReqB1 = 64'd50;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (oReqReady1) acc++;
         tick();
      end
      iReqValid1 = 1'b0;
      chk("clr_accepts", acc, 10);
      repeat (12) tick();
      chk("clr_pre_rsp", oRspValid, 1);
      iClr = 1'b1; iReqValid1 = 1'b1;
      #1;
      chk("clr_mul_clr", oMulClr, 1);
      chk("clr_ready", oReqReady1, 0);
      tick();
      iClr = 1'b0; iReqValid1 = 1'b0;
      #1;
      chk("clr_mul_clr_low", oMulClr, 0);
      iRspReady = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (oRspValid) bad++;
         tick();
      end
      iRspReady = 1'b0;
      chk("clr_no_rsp", bad, 0);
      chk("clr_cfg_kept", oMulMod, 97);
      single(1'b0, 64'd12, 64'd13, 64'd59, "post_clr");

      // Performance counters: 4 stalled cycles (config acceptance), 5 ch0 ops, 3 ch1 ops
      iClr = 1'b1; tick(); iClr = 1'b0;
      iCfgValid = 1'b1;
      iReqValid0 = 1'b1; iReqA0 = 64'd12; iReqB0 = 64'd13;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (oReqReady0) acc++;
         tick();
      end
      iCfgValid = 1'b0;
      chk("perf_stall_accepts", acc, 0);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (oReqReady0) acc++;
         tick();
      end
      iReqValid0 = 1'b0;
      iReqValid1 = 1'b1; iReqA1 = 64'd2; iReqB1 = 64'd50;
      acc1 = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (oReqReady1) acc1++;
         tick();
      end
      iReqValid1 = 1'b0;
      chk("perf_acc0", acc, 5);
      chk("perf_acc1", acc1, 3);
`ifdef BARRETT_SCHED_PERF_EN
      chk("perf_ops0", oPerfOps0, 5);
      chk("perf_ops1", oPerfOps1, 3);
      chk("perf_stall", oPerfStall, 4);
`else
      chk("perf_ops0", oPerfOps0, 0);
      chk("perf_ops1", oPerfOps1, 0);
      chk("perf_stall", oPerfStall, 0);
`endif
      iRspReady = 1'b1;
      n = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (oRspValid) begin
            if (oRspId != (n >= 5) || oRspData != ((n >= 5) ? 64'd3 : 64'd59)) bad++;
            n++;
         end
         tick();
      end
      iRspReady = 1'b0;
      chk("perf_rsp_count", n, 8);
      chk("perf_rsp_order", bad, 0);

      // Reset mid-operation drops configuration and in-flight work
      iReqValid0 = 1'b1;
      #1;
      chk("rst2_ready_before", oReqReady0, 1);
      tick();
      iRstN = 1'b0;
      #1;
      chk("rst2_mod", oMulMod, 0);
      chk("rst2_mul_a", oMulData0, 0);
      tick();
      iRstN = 1'b1;
      acc = 0; bad = 0;
      for (int i = 0; i < 25; i++) begin
         #1;
         if (oReqReady0) acc++;
         if (oRspValid) bad++;
         tick();
      end
      iReqValid0 = 1'b0;
      chk("rst2_no_accept", acc, 0);
      chk("rst2_no_rsp", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
